// File: rtl/time_set_ctrl.sv
// Time/alarm setting sequencer: walks hour/minute edit fields from MODE/INC/DEC
// press events, with hold auto-repeat, inactivity timeout and field blink.
module time_set_ctrl #(
  parameter int REPEAT_TICKS  = 20,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int BLINK_TICKS   = 50
) (
  input  logic       clk_100Hz,
  input  logic       rst_n,
  input  logic       mode_press,
  input  logic       mode_hold,
  input  logic       inc_press,
  input  logic       inc_hold,
  input  logic       dec_press,
  input  logic       dec_hold,
  input  logic [4:0] time_hr_in,
  input  logic [5:0] time_min_in,
  output logic [2:0] state,
  output logic [4:0] edit_hr,
  output logic [5:0] edit_min,
  output logic       time_load,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic       blink
);

  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    edit_hr_q, edit_hr_d, alarm_hr_q, alarm_hr_d;
  logic [5:0]    edit_min_q, edit_min_d, alarm_min_q, alarm_min_d;
  logic          time_load_q, time_load_d;
  logic          alarm_en_q, alarm_en_d;
  logic          blink_q, blink_d, blink_ph_q, blink_ph_d;
  logic          mode_hold_q, inc_hold_q, dec_hold_q;
  logic [RW-1:0] inc_rep_q, inc_rep_d, dec_rep_q, dec_rep_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  logic mode_rise, inc_rise, dec_rise, inc_rpt, dec_rpt, inc_src, dec_src;
  logic activity, in_set, step_ok, do_up, do_dn, hr_field;

  function automatic logic [4:0] hr_step(input logic [4:0] h, input logic up);
    if (up) return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
    if (up) return (m >= 6'd59) ? 6'd0 : m + 6'd1;
    return (m == 6'd0 || m > 6'd59) ? 6'd59 : m - 6'd1;
  endfunction

  // Counts cycles since the hold rose; wraps back to 1 on each repeat step.
  function automatic logic [RW-1:0] rep_next(input logic hold, input logic rise,
                                             input logic [RW-1:0] cnt);
    if (!hold) return '0;
    if (rise || cnt == RW'(REPEAT_TICKS)) return RW'(1);
    return cnt + RW'(1);
  endfunction

  assign mode_rise = mode_hold & ~mode_hold_q;
  assign inc_rise  = inc_hold & ~inc_hold_q;
  assign dec_rise  = dec_hold & ~dec_hold_q;
  assign inc_rpt   = inc_hold & ~inc_rise & ~dec_hold & (inc_rep_q == RW'(REPEAT_TICKS));
  assign dec_rpt   = dec_hold & ~dec_rise & ~inc_hold & (dec_rep_q == RW'(REPEAT_TICKS));
  assign inc_src   = inc_press | inc_rise | inc_rpt;
  assign dec_src   = dec_press | dec_rise | dec_rpt;
  assign activity  = mode_press | inc_press | dec_press | mode_hold | inc_hold | dec_hold;
  assign in_set    = (state_q != IDLE);
  // The first SET_AHR cycle reloads the edit fields from the alarm, so steps wait.
  assign step_ok   = in_set & ~mode_press & ~time_load_q;
  assign do_up     = step_ok & inc_src & ~dec_src;
  assign do_dn     = step_ok & dec_src & ~inc_src;
  assign hr_field  = (state_q == SET_HR) || (state_q == SET_AHR);

  always_comb begin
    state_d     = state_q;
    edit_hr_d   = edit_hr_q;
    edit_min_d  = edit_min_q;
    alarm_hr_d  = alarm_hr_q;
    alarm_min_d = alarm_min_q;
    alarm_en_d  = alarm_en_q;
    time_load_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mode_press) begin
          state_d    = SET_HR;
          edit_hr_d  = (time_hr_in > 5'd23) ? 5'd23 : time_hr_in;
          edit_min_d = (time_min_in > 6'd59) ? 6'd59 : time_min_in;
        end
        if (mode_rise) alarm_en_d = ~alarm_en_q;
      end
      SET_HR:  if (mode_press) state_d = SET_MIN;
      SET_MIN: begin
        if (mode_press) begin
          state_d     = SET_AHR;
          time_load_d = 1'b1;
        end
      end
      SET_AHR: if (mode_press) state_d = SET_AMIN;
      SET_AMIN: begin
        if (mode_press) begin
          state_d     = IDLE;
          alarm_hr_d  = edit_hr_q;
          alarm_min_d = edit_min_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_set && !activity && to_cnt_q == TW'(TIMEOUT_TICKS - 1)) state_d = IDLE;

    if (do_up || do_dn) begin
      if (hr_field) edit_hr_d  = hr_step(edit_hr_q, do_up);
      else          edit_min_d = min_step(edit_min_q, do_up);
    end

    // time_load is high while edit_* still holds the time; swap to the alarm afterwards.
    if (time_load_q) begin
      edit_hr_d  = alarm_hr_q;
      edit_min_d = alarm_min_q;
    end

    if (state_d != state_q || activity || !in_set) to_cnt_d = '0;
    else                                           to_cnt_d = to_cnt_q + TW'(1);

    if (state_d != state_q || state_d == IDLE) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_ph_d  = blink_ph_q;
    end
    blink_d = (state_d != IDLE) & blink_ph_d & ~(do_up | do_dn);

    inc_rep_d = rep_next(inc_hold, inc_rise, inc_rep_q);
    dec_rep_d = rep_next(dec_hold, dec_rise, dec_rep_q);
  end

  always_ff @(posedge clk_100Hz) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      edit_hr_q   <= '0;
      edit_min_q  <= '0;
      alarm_hr_q  <= '0;
      alarm_min_q <= '0;
      alarm_en_q  <= 1'b0;
      time_load_q <= 1'b0;
      blink_q     <= 1'b0;
      blink_ph_q  <= 1'b0;
      blink_cnt_q <= '0;
      to_cnt_q    <= '0;
      inc_rep_q   <= '0;
      dec_rep_q   <= '0;
      mode_hold_q <= 1'b0;
      inc_hold_q  <= 1'b0;
      dec_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      edit_hr_q   <= edit_hr_d;
      edit_min_q  <= edit_min_d;
      alarm_hr_q  <= alarm_hr_d;
      alarm_min_q <= alarm_min_d;
      alarm_en_q  <= alarm_en_d;
      time_load_q <= time_load_d;
      blink_q     <= blink_d;
      blink_ph_q  <= blink_ph_d;
      blink_cnt_q <= blink_cnt_d;
      to_cnt_q    <= to_cnt_d;
      inc_rep_q   <= inc_rep_d;
      dec_rep_q   <= dec_rep_d;
      mode_hold_q <= mode_hold;
      inc_hold_q  <= inc_hold;
      dec_hold_q  <= dec_hold;
    end
  end

  assign state     = state_q;
  assign edit_hr   = edit_hr_q;
  assign edit_min  = edit_min_q;
  assign time_load = time_load_q;
  assign alarm_hr  = alarm_hr_q;
  assign alarm_min = alarm_min_q;
  assign alarm_en  = alarm_en_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed and randomized bench for time_set_ctrl against a cycle-level reference model.
module tb_time_set_ctrl;
  localparam int REP = 20;
  localparam int TO  = 1000;
  localparam int BL  = 50;

  logic       clk_100Hz = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_press = 1'b0, mode_hold = 1'b0;
  logic       inc_press = 1'b0, inc_hold = 1'b0;
  logic       dec_press = 1'b0, dec_hold = 1'b0;
  logic [4:0] time_hr_in = '0;
  logic [5:0] time_min_in = '0;
  logic [2:0] state;
  logic [4:0] edit_hr, alarm_hr;
  logic [5:0] edit_min, alarm_min;
  logic       time_load, alarm_en, blink;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_state = 0, m_ehr = 0, m_emin = 0, m_ahr = 0, m_amin = 0;
  bit m_aen = 0, m_tl = 0, m_blink = 0;
  int quiet = 0, since = 0, inc_age = -1, dec_age = -1;
  bit pm = 0, pi = 0, pd = 0;

  time_set_ctrl #(.REPEAT_TICKS(REP), .TIMEOUT_TICKS(TO), .BLINK_TICKS(BL)) dut (
    .clk_100Hz(clk_100Hz), .rst_n(rst_n),
    .mode_press(mode_press), .mode_hold(mode_hold),
    .inc_press(inc_press), .inc_hold(inc_hold),
    .dec_press(dec_press), .dec_hold(dec_hold),
    .time_hr_in(time_hr_in), .time_min_in(time_min_in),
    .state(state), .edit_hr(edit_hr), .edit_min(edit_min), .time_load(time_load),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_en(alarm_en), .blink(blink)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state", int'(state), m_state);
    check("edit_hr", int'(edit_hr), m_ehr);
    check("edit_min", int'(edit_min), m_emin);
    check("time_load", int'(time_load), int'(m_tl));
    check("alarm_hr", int'(alarm_hr), m_ahr);
    check("alarm_min", int'(alarm_min), m_amin);
    check("alarm_en", int'(alarm_en), int'(m_aen));
    check("blink", int'(blink), int'(m_blink));
  endtask

  // One clock: predict from the inputs present at the edge, clock, then compare everything.
  task automatic cyc();
    int ns, nehr, nemin, nahr, namin, nia, nda;
    bit naen, ntl, stepped, mr, ir, dr, irep, drep, isrc, dsrc, act;
    bit hm, hi, hd;
    hm = mode_hold; hi = inc_hold; hd = dec_hold;
    if (!rst_n) begin
      ns = 0; nehr = 0; nemin = 0; nahr = 0; namin = 0; naen = 0; ntl = 0; stepped = 0;
      nia = -1; nda = -1; hm = 0; hi = 0; hd = 0;
      quiet = 0; since = 0; m_blink = 0;
    end else begin
      mr = hm && !pm; ir = hi && !pi; dr = hd && !pd;
      nia = !hi ? -1 : (ir ? 0 : inc_age + 1);
      nda = !hd ? -1 : (dr ? 0 : dec_age + 1);
      irep = hi && !ir && !hd && nia > 0 && (nia % REP) == 0;
      drep = hd && !dr && !hi && nda > 0 && (nda % REP) == 0;
      isrc = inc_press || ir || irep;
      dsrc = dec_press || dr || drep;
      act  = mode_press || inc_press || dec_press || hm || hi || hd;
      ns = m_state; nehr = m_ehr; nemin = m_emin; nahr = m_ahr; namin = m_amin;
      naen = m_aen; ntl = 0; stepped = 0;
      if (m_state == 0) begin
        if (mode_press) begin
          ns = 1;
          nehr  = (time_hr_in > 23) ? 23 : int'(time_hr_in);
          nemin = (time_min_in > 59) ? 59 : int'(time_min_in);
        end
        if (mr) naen = !m_aen;
      end else if (mode_press) begin
        ns = (m_state + 1) % 5;
        if (m_state == 2) ntl = 1;
        if (m_state == 4) begin nahr = m_ehr; namin = m_emin; end
      end else if (!act && quiet + 1 == TO) begin
        ns = 0;
      end else if (!m_tl && isrc != dsrc) begin
        stepped = 1;
        if (m_state == 1 || m_state == 3) nehr = isrc ? (m_ehr + 1) % 24 : (m_ehr + 23) % 24;
        else nemin = isrc ? (m_emin + 1) % 60 : (m_emin + 59) % 60;
      end
      if (m_tl) begin nehr = m_ahr; nemin = m_amin; end
      quiet = (ns != m_state || act || ns == 0) ? 0 : quiet + 1;
      since = (ns != m_state || ns == 0) ? 0 : since + 1;
      m_blink = (ns != 0) && ((since / BL) % 2 == 1) && !stepped;
    end
    @(posedge clk_100Hz);
    #1;
    m_state = ns; m_ehr = nehr; m_emin = nemin; m_ahr = nahr; m_amin = namin;
    m_aen = naen; m_tl = ntl; inc_age = nia; dec_age = nda;
    pm = hm; pi = hi; pd = hd;
    mode_press = 0; inc_press = 0; dec_press = 0;
    check_all();
  endtask

  initial begin
    // Reset
    repeat (2) cyc();
    check("rst_state", int'(state), 0);
    check("rst_alarm_en", int'(alarm_en), 0);
    rst_n = 1;
    cyc();

    // Alarm enable toggles once per MODE hold in IDLE
    mode_hold = 1; cyc();
    check("aen_on", int'(alarm_en), 1);
    repeat (3) cyc();
    check("aen_held", int'(alarm_en), 1);
    mode_hold = 0; cyc();
    mode_hold = 1; cyc();
    check("aen_off", int'(alarm_en), 0);
    mode_hold = 0; cyc();

    // Time edit with wrap, then commit via time_load
    time_hr_in = 23; time_min_in = 59;
    mode_press = 1; cyc();
    check("load_hr", int'(edit_hr), 23);
    check("load_min", int'(edit_min), 59);
    inc_press = 1; cyc();
    check("hr_wrap_up", int'(edit_hr), 0);
    check("blink_step", int'(blink), 0);
    dec_press = 1; cyc();
    check("hr_wrap_dn", int'(edit_hr), 23);
    inc_press = 1; cyc();
    mode_press = 1; cyc();
    dec_press = 1; cyc();
    check("min_dec", int'(edit_min), 58);
    mode_press = 1; cyc();
    check("tl_pulse", int'(time_load), 1);
    check("tl_state", int'(state), 3);
    check("tl_hr", int'(edit_hr), 0);
    check("tl_min", int'(edit_min), 58);
    cyc();
    check("tl_end", int'(time_load), 0);
    check("ahr_loaded", int'(edit_hr), 0);

    // Alarm 7:00, then auto-repeat minutes
    repeat (7) begin inc_press = 1; cyc(); end
    check("ahr_7", int'(edit_hr), 7);
    mode_press = 1; cyc();
    check("amin_state", int'(state), 4);
    inc_hold = 1;
    repeat (61) cyc();
    inc_hold = 0; cyc();
    check("repeat4", int'(edit_min), 4);
    mode_press = 1; cyc();
    check("commit_state", int'(state), 0);
    check("commit_ahr", int'(alarm_hr), 7);
    check("commit_amin", int'(alarm_min), 4);

    // Timeout from SET_AHR
    repeat (3) begin mode_press = 1; cyc(); end
    check("to_entry", int'(state), 3);
    repeat (60) cyc();
    check("blink_on", int'(blink), 1);
    repeat (939) cyc();
    check("to_not_yet", int'(state), 3);
    cyc();
    check("to_idle", int'(state), 0);
    check("to_no_tl", int'(time_load), 0);
    check("to_ahr", int'(alarm_hr), 7);
    check("to_amin", int'(alarm_min), 4);

    // Simultaneous events
    time_hr_in = 5; time_min_in = 30;
    mode_press = 1; cyc();
    inc_press = 1; dec_press = 1; cyc();
    check("incdec_same", int'(edit_hr), 5);
    mode_press = 1; inc_press = 1; cyc();
    check("mode_wins_st", int'(state), 2);
    check("mode_wins_hr", int'(edit_hr), 5);
    check("mode_wins_min", int'(edit_min), 30);
    inc_hold = 1; dec_hold = 1;
    repeat (25) cyc();
    inc_hold = 0; dec_hold = 0; cyc();
    check("both_holds", int'(edit_min), 30);

    // Reset mid-edit
    rst_n = 0; cyc();
    check("rst_mid_st", int'(state), 0);
    check("rst_mid_tl", int'(time_load), 0);
    check("rst_mid_ahr", int'(alarm_hr), 0);
    check("rst_mid_emin", int'(edit_min), 0);
    rst_n = 1; cyc();

    // Out-of-range time inputs clamp at load
    time_hr_in = 30; time_min_in = 63;
    mode_press = 1; cyc();
    check("clamp_hr", int'(edit_hr), 23);
    check("clamp_min", int'(edit_min), 59);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mode_press = ($urandom_range(0, 11) == 0);
      inc_press  = ($urandom_range(0, 5) == 0);
      dec_press  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) inc_hold  = ~inc_hold;
      if ($urandom_range(0, 39) == 0) dec_hold  = ~dec_hold;
      if ($urandom_range(0, 59) == 0) mode_hold = ~mode_hold;
      time_hr_in  = 5'($urandom_range(0, 31));
      time_min_in = 6'($urandom_range(0, 63));
      rst_n = ($urandom_range(0, 799) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
